// File: rtl/tt_um_umar316798_pwm.sv
// Multi-channel PWM generator with double-buffered duty/period registers,
// a shared prescaler and edge- or center-aligned counting, wrapped in the
// Tiny Tapeout user-project shell.
module tt_um_umar316798_pwm #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRE_W    = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned       ADDR_W      = 4;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd9;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [15:0]         s1;
    logic                s2_stb;
    logic                en;
    logic                mode;
    logic [PRE_W-1:0]    pre;
    logic [PRE_W-1:0]    pcnt;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_nxt;
    logic [WIDTH-1:0]    top_sh;
    logic [WIDTH-1:0]    top_act;
    logic [WIDTH-1:0]    duty_sh  [CHANNELS];
    logic [WIDTH-1:0]    duty_act [CHANNELS];
    dir_t                dir;
    dir_t                dir_nxt;
    logic [CHANNELS-1:0] pwm;
    logic                wr;
    logic                tick;
    logic                load;
    logic                mode_chg;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_data;
    logic                unused_bits;

    // A write fires once per rising edge of the captured strobe
    assign wr       = s1[15] & ~s2_stb;
    assign wr_addr  = s1[11:8];
    assign wr_data  = s1[7:0];
    assign tick     = en & (pcnt == pre);
    assign mode_chg = wr & (wr_addr == ADDR_CTRL) & (wr_data[1] != mode);

    assign uo_out      = 8'(pwm);
    assign uio_out     = 8'h00;
    assign uio_oe      = 8'h00;
    assign unused_bits = &{1'b0, s1[14:12], wr_data};

    // Counter/direction next state and load-point detection
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        load    = 1'b0;
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
            load    = 1'b1;
        end else if (tick) begin
            if (!mode) begin
                if (cnt >= top_act) begin
                    cnt_nxt = '0;
                    load    = 1'b1;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else if (top_act == '0) begin
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
                load    = 1'b1;
            end else if ((dir == DIR_UP) && (cnt < top_act)) begin
                cnt_nxt = cnt + WIDTH'(1);
                if (cnt_nxt == top_act) begin
                    dir_nxt = DIR_DOWN;
                end
            end else if (cnt <= WIDTH'(1)) begin
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
                load    = 1'b1;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
                dir_nxt = DIR_DOWN;
            end
        end
        if (mode_chg) begin
            dir_nxt = DIR_UP;
        end
    end

    // Two-stage capture of the register port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2_stb <= 1'b0;
        end else if (ena) begin
            s1     <= {ui_in, uio_in};
            s2_stb <= s1[15];
        end
    end

    // Control register and shadow/active register banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en      <= 1'b0;
            mode    <= 1'b0;
            pre     <= '0;
            top_sh  <= '1;
            top_act <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else if (ena) begin
            if (load) begin
                top_act <= top_sh;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act[i] <= duty_sh[i];
                end
            end
            if (wr) begin
                if (wr_addr == ADDR_PERIOD) begin
                    top_sh <= wr_data[WIDTH-1:0];
                end
                if (wr_addr == ADDR_CTRL) begin
                    en   <= wr_data[0];
                    mode <= wr_data[1];
                    pre  <= wr_data[4+PRE_W-1:4];
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    if (wr_addr == ADDR_W'(i)) begin
                        duty_sh[i] <= wr_data[WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Prescaler and PWM counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            cnt  <= '0;
            dir  <= DIR_UP;
        end else if (ena) begin
            pcnt <= (!en || tick) ? '0 : pcnt + PRE_W'(1);
            cnt  <= cnt_nxt;
            dir  <= dir_nxt;
        end
    end

    // Registered compare outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= '0;
        end else if (ena) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= en & (cnt < duty_act[i]);
            end
        end
    end

endmodule

// File: tb/tb_tt_um_umar316798_pwm.sv
// Self-checking bench for tt_um_umar316798_pwm: directed scenarios plus
// randomized programming, checked against a phase-based reference model.
module tb_tt_um_umar316798_pwm;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tt_um_umar316798_pwm dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    // Reference model: the counter is described by a phase within the period
    int         m_en, m_mode, m_pre, m_pcnt, m_phase, m_top_sh, m_top;
    int         m_duty_sh [8];
    int         m_duty    [8];
    logic       m_s1_stb, m_s2_stb;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] exp_out;

    function automatic int cnt_of(input int ph, input int top, input int mode);
        if (mode == 0 || ph <= top) return ph;
        return 2 * top - ph;
    endfunction

    function automatic int period_of(input int top, input int mode);
        if (top == 0) return 1;
        return (mode != 0) ? 2 * top : top + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int   c;
        logic w;
        if (!rst_n) begin
            m_en = 0; m_mode = 0; m_pre = 0; m_pcnt = 0; m_phase = 0;
            m_top_sh = 255; m_top = 255;
            for (int i = 0; i < 8; i++) begin
                m_duty_sh[i] = 0;
                m_duty[i]    = 0;
            end
            m_s1_stb = 1'b0; m_s2_stb = 1'b0; m_addr = 4'h0; m_data = 8'h00;
            exp_out = 8'h00;
        end else if (ena) begin
            c = cnt_of(m_phase, m_top, m_mode);
            for (int i = 0; i < 8; i++) exp_out[i] = (m_en != 0) && (c < m_duty[i]);
            w = m_s1_stb && !m_s2_stb;
            if (m_en == 0) begin
                m_pcnt = 0;
                m_phase = 0;
                m_top = m_top_sh;
                for (int i = 0; i < 8; i++) m_duty[i] = m_duty_sh[i];
            end else if (m_pcnt == m_pre) begin
                m_pcnt = 0;
                m_phase++;
                if (m_phase >= period_of(m_top, m_mode)) begin
                    m_phase = 0;
                    m_top = m_top_sh;
                    for (int i = 0; i < 8; i++) m_duty[i] = m_duty_sh[i];
                end
            end else begin
                m_pcnt++;
            end
            if (w) begin
                if (m_addr < 4'd8) m_duty_sh[m_addr] = int'(m_data);
                else if (m_addr == 4'd8) m_top_sh = int'(m_data);
                else if (m_addr == 4'd9) begin
                    m_en   = int'(m_data[0]);
                    m_mode = int'(m_data[1]);
                    m_pre  = int'(m_data[7:4]);
                end
            end
            m_s2_stb = m_s1_stb;
            m_s1_stb = ui_in[7];
            m_addr   = ui_in[3:0];
            m_data   = uio_in;
        end
    end

    // Register write: strobe high for two clocks, then low for one
    task automatic wr_reg(input logic [3:0] addr, input logic [7:0] data);
        ui_in  = {1'b1, 3'b000, addr};
        uio_in = data;
        repeat (2) @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(negedge clk);
    endtask

    // Strobe held for several clocks; data changes after the capture window
    task automatic wr_hold(input logic [3:0] addr, input logic [7:0] d0,
                           input logic [7:0] d1, input int hold);
        ui_in  = {1'b1, 3'b000, addr};
        uio_in = d0;
        repeat (2) @(negedge clk);
        uio_in = d1;
        repeat (hold - 2) @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ui_in  = 8'h89;
        uio_in = 8'h5a;
        repeat (3) @(negedge clk);
        n_total++;
        if (uo_out !== 8'h00) $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        else n_pass++;
        n_total++;
        if (uio_oe !== 8'h00) $display("FAIL reset_uio_oe: got %h expected 00", uio_oe);
        else n_pass++;
        n_total++;
        if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h expected 00", uio_out);
        else n_pass++;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_total++;
        if (uo_out !== 8'h00) $display("FAIL reset_release_idle: got %h expected 00", uo_out);
        else n_pass++;
    endtask

    task automatic test_default_period();
        int c0 = 0;
        int c1 = 0;
        wr_reg(4'd0, 8'd200);
        wr_reg(4'd1, 8'd255);
        wr_reg(4'd9, 8'h01);
        for (int k = 0; k < 256; k++) begin
            n_total++;
            if (uo_out !== exp_out) $display("FAIL default_track: k=%0d got %h expected %h", k, uo_out, exp_out);
            else n_pass++;
            c0 += int'(uo_out[0]);
            c1 += int'(uo_out[1]);
            @(negedge clk);
        end
        n_total++;
        if (c0 != 200) $display("FAIL default_duty200: got %0d expected 200", c0);
        else n_pass++;
        n_total++;
        if (c1 != 255) $display("FAIL default_duty255: got %0d expected 255", c1);
        else n_pass++;
    endtask

    task automatic test_edge_basic();
        int   c0 = 0, c1 = 0, c2 = 0, rises = 0, last_rise = -1;
        logic prev = 1'b0;
        wr_reg(4'd9, 8'h00);
        wr_reg(4'd8, 8'd9);
        wr_reg(4'd0, 8'd3);
        wr_reg(4'd1, 8'd0);
        wr_reg(4'd2, 8'd10);
        wr_reg(4'd9, 8'h01);
        for (int k = 0; k < 30; k++) begin
            n_total++;
            if (uo_out !== exp_out) $display("FAIL edge_track: k=%0d got %h expected %h", k, uo_out, exp_out);
            else n_pass++;
            if (uo_out[0] && !prev) begin
                rises++;
                last_rise = k;
            end
            prev = uo_out[0];
            c0 += int'(uo_out[0]);
            c1 += int'(uo_out[1]);
            c2 += int'(uo_out[2]);
            @(negedge clk);
        end
        n_total++;
        if (c0 != 9) $display("FAIL edge_duty3: got %0d expected 9", c0);
        else n_pass++;
        n_total++;
        if (rises != 3 || last_rise != 20) $display("FAIL edge_period: got rises=%0d last=%0d expected 3/20", rises, last_rise);
        else n_pass++;
        n_total++;
        if (c1 != 0) $display("FAIL edge_duty0: got %0d expected 0", c1);
        else n_pass++;
        n_total++;
        if (c2 != 30) $display("FAIL edge_duty_over_top: got %0d expected 30", c2);
        else n_pass++;
    endtask

    task automatic test_glitch_free();
        int   c_cur = 0, c_next = 0;
        logic prev = uo_out[0];
        logic found = 1'b0;
        for (int k = 0; k < 25 && !found; k++) begin
            @(negedge clk);
            if (uo_out[0] && !prev) found = 1'b1;
            prev = uo_out[0];
        end
        n_total++;
        if (!found) begin
            $display("FAIL glitch_wait_rise: got no rise expected one within 25 clocks");
            return;
        end
        n_pass++;
        fork
            begin
                repeat (4) @(negedge clk);
                wr_hold(4'd0, 8'd7, 8'd1, 5);
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    n_total++;
                    if (uo_out !== exp_out) $display("FAIL glitch_track: k=%0d got %h expected %h", k, uo_out, exp_out);
                    else n_pass++;
                    if (k < 10) c_cur += int'(uo_out[0]);
                    else c_next += int'(uo_out[0]);
                    @(negedge clk);
                end
            end
        join
        n_total++;
        if (c_cur != 3) $display("FAIL glitch_current_period: got %0d expected 3", c_cur);
        else n_pass++;
        n_total++;
        if (c_next != 7) $display("FAIL glitch_next_period: got %0d expected 7", c_next);
        else n_pass++;
    endtask

    task automatic test_center();
        logic v [48];
        int   exp_hi = 0, r1 = -1, r2 = -1, run = 0;
        for (int ph = 0; ph < 8; ph++) if (cnt_of(ph, 4, 1) < 2) exp_hi += 2;
        wr_reg(4'd9, 8'h00);
        wr_reg(4'd8, 8'd4);
        wr_reg(4'd0, 8'd2);
        wr_reg(4'd9, 8'h13);
        for (int k = 0; k < 48; k++) begin
            n_total++;
            if (uo_out !== exp_out) $display("FAIL center_track: k=%0d got %h expected %h", k, uo_out, exp_out);
            else n_pass++;
            v[k] = uo_out[0];
            @(negedge clk);
        end
        for (int k = 1; k < 48; k++) begin
            if (v[k] && !v[k-1]) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
        end
        if (r1 >= 0) begin
            for (int k = r1; k < 48 && v[k]; k++) run++;
        end
        n_total++;
        if (r1 < 0 || r2 < 0 || (r2 - r1) != 16) $display("FAIL center_period: got r1=%0d r2=%0d expected spacing 16", r1, r2);
        else n_pass++;
        n_total++;
        if (run != exp_hi) $display("FAIL center_high_run: got %0d expected %0d", run, exp_hi);
        else n_pass++;
    endtask

    task automatic test_freeze();
        logic [7:0] held;
        repeat ($urandom_range(3, 10)) @(negedge clk);
        ena  = 1'b0;
        held = uo_out;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                ui_in  = 8'h80;
                uio_in = 8'hff;
            end
            if (k == 12) begin
                ui_in  = 8'h00;
                uio_in = 8'h00;
            end
            @(negedge clk);
            n_total++;
            if (uo_out !== held) $display("FAIL freeze_hold: k=%0d got %h expected %h", k, uo_out, held);
            else n_pass++;
        end
        ena = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_total++;
            if (uo_out !== exp_out) $display("FAIL freeze_resume: k=%0d got %h expected %h", k, uo_out, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_disable();
        int c0 = 0;
        wr_reg(4'd9, 8'h02);
        n_total++;
        if (uo_out !== 8'h00) $display("FAIL disable_forces_zero: got %h expected 00", uo_out);
        else n_pass++;
        wr_reg(4'd8, 8'd9);
        wr_reg(4'd0, 8'd3);
        wr_reg(4'd9, 8'h01);
        n_total++;
        if (uo_out[0] !== 1'b1) $display("FAIL reenable_first_high: got %b expected 1", uo_out[0]);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            n_total++;
            if (uo_out !== exp_out) $display("FAIL reenable_track: k=%0d got %h expected %h", k, uo_out, exp_out);
            else n_pass++;
            c0 += int'(uo_out[0]);
            @(negedge clk);
        end
        n_total++;
        if (c0 != 3) $display("FAIL reenable_duty: got %0d expected 3", c0);
        else n_pass++;
    endtask

    task automatic test_random();
        int top, mode, pre, r;
        for (int it = 0; it < 8; it++) begin
            top  = $urandom_range(0, 12);
            mode = $urandom_range(0, 1);
            pre  = $urandom_range(0, 2);
            wr_reg(4'd9, 8'(mode << 1));
            wr_reg(4'd8, 8'(top));
            for (int ch = 0; ch < 8; ch++) wr_reg(4'(ch), 8'($urandom_range(0, top + 2)));
            wr_reg(4'd9, 8'((pre << 4) | (mode << 1) | 1));
            for (int k = 0; k < 80; k++) begin
                r = $urandom_range(0, 24);
                if (r == 0) begin
                    wr_reg(4'($urandom_range(0, 8)), 8'($urandom_range(0, 14)));
                end else if (r == 1) begin
                    wr_reg(4'($urandom_range(10, 15)), 8'($urandom));
                end else if (r == 2) begin
                    ena = 1'b0;
                    repeat ($urandom_range(1, 5)) @(negedge clk);
                    ena = 1'b1;
                end
                n_total++;
                if (uo_out !== exp_out) $display("FAIL random_track: it=%0d k=%0d got %h expected %h", it, k, uo_out, exp_out);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_default_period();
        test_edge_basic();
        test_glitch_free();
        test_center();
        test_freeze();
        test_disable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
